key_bank: RTL and testbench

- Parametrised N-channel push-button conditioner, successor to the single-key debouncer.
- Each channel has:
  - a saturating up/down integrator with separate press/release hysteresis thresholds;
  - selectable level/toggle output;
  - one-cycle rise/fall pulses;
  - a long-press flag.
- Sits between raw board key pins and the CPU/IO register block; one instance serves the whole key bank.

---
 rtl/key_pkg.sv | 18 +
 rtl/key_chan.sv | 89 ++++++++
 rtl/key_bank.sv | 49 ++++
 tb/tb_key_bank.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and parameter sanity check for the key bank conditioner.
package key_pkg;

    localparam int ON_TH_DEF    = 896;
    localparam int OFF_TH_DEF   = 255;
    localparam int LONG_CYC_DEF = 1000000;

    // Hysteresis must be ordered and reachable, and the long-press count must fit its counter.
    function automatic bit th_ok(input int cnt_w, input int on_th, input int off_th,
                                 input int lp_w, input int long_cyc);
        longint cnt_max;
        longint lp_max;
        cnt_max = (longint'(1) << cnt_w) - 1;
        lp_max  = (longint'(1) << lp_w);
        return (off_th < on_th) && (longint'(on_th) <= cnt_max) && (longint'(long_cyc) < lp_max);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: optional synchroniser (KEY_SYNC_EN), hysteretic integrator,
// level/toggle output, edge pulses and long-press flag.
module key_chan
    import key_pkg::*;
#(
    parameter int CNT_W    = 11,
    parameter int ON_TH    = ON_TH_DEF,
    parameter int OFF_TH   = OFF_TH_DEF,
    parameter int LP_W     = 20,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic mode,
    output logic press,
    output logic spress,
    output logic rspress,
    output logic rise,
    output logic fall,
    output logic long
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ON_V    = CNT_W'(ON_TH);
    localparam logic [CNT_W-1:0] OFF_V   = CNT_W'(OFF_TH);
    localparam logic [LP_W-1:0]  LC_V    = LP_W'(LONG_CYC);

    logic key;

`ifdef KEY_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[0], in};
    end
    assign key = sync[1];
`else
    assign key = in;
`endif

    assign spress = key;

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [LP_W-1:0]  hold, hold_n;
    logic             snd, snd_n, rise_n, sw;

    always_comb begin
        if (key) cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else     cnt_n = (cnt == '0)      ? cnt : cnt - 1'b1;
        snd_n = snd;
        if (key && cnt_n >= ON_V)        snd_n = 1'b1;
        else if (!key && cnt_n <= OFF_V) snd_n = 1'b0;
    end

    assign rise_n = ~snd & snd_n;
    assign hold_n = (hold == LC_V) ? hold : hold + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            snd  <= 1'b0;
            sw   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            long <= 1'b0;
            hold <= '0;
        end else begin
            cnt  <= cnt_n;
            snd  <= snd_n;
            rise <= rise_n;
            fall <= snd & ~snd_n;
            if (!mode)       sw <= snd_n;
            else if (rise_n) sw <= ~sw;
            // Counting starts the cycle after rise, so long lands LONG_CYC cycles after it.
            if (!snd_n) begin
                hold <= '0;
                long <= 1'b0;
            end else if (snd) begin
                hold <= hold_n;
                long <= (hold_n == LC_V);
            end
        end
    end

    assign press   = sw;
    assign rspress = snd;

endmodule

// File: rtl/key_bank.sv
// N independent push-button conditioners; KEY_SYNC_EN adds a 2-flop input synchroniser.
module key_bank
    import key_pkg::*;
#(
    parameter int N        = 4,
    parameter int CNT_W    = 11,
    parameter int ON_TH    = ON_TH_DEF,
    parameter int OFF_TH   = OFF_TH_DEF,
    parameter int LP_W     = 20,
    parameter int LONG_CYC = LONG_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic [N-1:0] mode,
    output logic [N-1:0] press,
    output logic [N-1:0] spress,
    output logic [N-1:0] rspress,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long
);

    if (!th_ok(CNT_W, ON_TH, OFF_TH, LP_W, LONG_CYC)) begin : g_bad_param
        $error("key_bank: need OFF_TH < ON_TH <= 2^CNT_W-1 and LONG_CYC < 2^LP_W");
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        key_chan #(
            .CNT_W   (CNT_W),
            .ON_TH   (ON_TH),
            .OFF_TH  (OFF_TH),
            .LP_W    (LP_W),
            .LONG_CYC(LONG_CYC)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .in     (in[i]),
            .mode   (mode[i]),
            .press  (press[i]),
            .spress (spress[i]),
            .rspress(rspress[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .long   (long[i])
        );
    end

endmodule

// File: tb/tb_key_bank.sv
// Bench for key_bank (N=2, CNT_W=4, ON_TH=12, OFF_TH=3, LONG_CYC=20): per-cycle model plus literal checks.
module tb_key_bank;

    localparam int N = 2;
    localparam int CMAX = 15;
    localparam int ONT = 12;
    localparam int OFFT = 3;
    localparam int LC = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] in = '0;
    logic [N-1:0] mode = '0;
    logic [N-1:0] press, spress, rspress, rise, fall, long;

    int tests = 0;
    int failed = 0;

    key_bank #(.N(N), .CNT_W(4), .ON_TH(ONT), .OFF_TH(OFFT), .LP_W(8), .LONG_CYC(LC)) dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode), .press(press), .spress(spress),
        .rspress(rspress), .rise(rise), .fall(fall), .long(long)
    );

    always #5 clk = ~clk;

    // Model state, interpreted as "after the most recent rising edge".
    int m_cnt [N];
    int m_rise_at [N];
    bit [N-1:0] m_snd = '0, m_press = '0, m_rise = '0, m_fall = '0, m_long = '0;
    int ecount = 0;

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Inputs change only just after a falling edge, so at each falling edge the current
    // in/mode/rst are exactly what the previous rising edge sampled.
    initial begin
        for (int c = 0; c < N; c++) begin
            m_cnt[c] = 0;
            m_rise_at[c] = 0;
        end
        forever begin
            @(negedge clk);
            ecount++;
            for (int c = 0; c < N; c++) begin
                if (!rst) begin
                    m_cnt[c] = 0;
                    m_snd[c] = 0;
                    m_press[c] = 0;
                    m_rise[c] = 0;
                    m_fall[c] = 0;
                end else begin
                    int nc;
                    bit ns;
                    nc = in[c] ? ((m_cnt[c] >= CMAX) ? CMAX : m_cnt[c] + 1)
                               : ((m_cnt[c] <= 0) ? 0 : m_cnt[c] - 1);
                    ns = m_snd[c];
                    if (in[c] && nc >= ONT) ns = 1;
                    if (!in[c] && nc <= OFFT) ns = 0;
                    m_rise[c] = !m_snd[c] && ns;
                    m_fall[c] = m_snd[c] && !ns;
                    if (m_rise[c]) m_rise_at[c] = ecount;
                    if (!mode[c]) m_press[c] = ns;
                    else if (m_rise[c]) m_press[c] = !m_press[c];
                    m_cnt[c] = nc;
                    m_snd[c] = ns;
                end
                m_long[c] = m_snd[c] && (ecount - m_rise_at[c] >= LC);
            end
            cmp("m_press", press, m_press);
            cmp("m_spress", spress, in);
            cmp("m_rspress", rspress, m_snd);
            cmp("m_rise", rise, m_rise);
            cmp("m_fall", fall, m_fall);
            cmp("m_long", long, m_long);
            if ((rise & fall) != '0) cmp("rise_fall_excl", rise & fall, '0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held with keys pressed
        in = 2'b11;
        rst = 1'b0;
        tick(3);
        cmp("rst_rspress", rspress, 2'b00);
        cmp("rst_press", press, 2'b00);
        cmp("rst_long", long, 2'b00);
        cmp("rst_spress", spress, 2'b11);
        rst = 1'b1;
        tick(11);
        cmp("rst_edge11", rspress, 2'b00);
        tick(1);
        cmp("rst_edge12", rspress, 2'b11);
        cmp("rst_rise12", rise, 2'b11);
        tick(1);
        cmp("rst_rise_gone", rise, 2'b00);
        in = 2'b00;
        tick(20);

        // Clean press/release on channel 0, level mode
        in = 2'b01;
        tick(11);
        cmp("clean_edge11", rspress, 2'b00);
        tick(1);
        cmp("clean_rspress", rspress, 2'b01);
        cmp("clean_press", press, 2'b01);
        cmp("clean_rise", rise, 2'b01);
        tick(1);
        cmp("clean_rise1cyc", rise, 2'b00);
        tick(10);
        in = 2'b00;
        tick(11);
        cmp("rel_edge11", rspress, 2'b01);
        tick(1);
        cmp("rel_fall", fall, 2'b01);
        cmp("rel_rspress", rspress, 2'b00);
        tick(1);
        cmp("rel_fall1cyc", fall, 2'b00);
        tick(5);

        // Bounce: alternating input never qualifies
        for (int k = 0; k < 30; k++) begin
            in = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick(1);
        end
        cmp("bounce_rspress", rspress, 2'b00);
        in = 2'b00;
        tick(3);

        // Toggle mode on channel 1
        mode = 2'b10;
        for (int p = 0; p < 2; p++) begin
            in = 2'b10;
            tick(12);
            cmp("tog_rise", rise, 2'b10);
            cmp("tog_press", press, (p == 0) ? 2'b10 : 2'b00);
            tick(3);
            in = 2'b00;
            tick(12);
            cmp("tog_fall", fall, 2'b10);
            cmp("tog_hold", press, (p == 0) ? 2'b10 : 2'b00);
            tick(4);
        end

        // Long press on channel 0
        in = 2'b01;
        tick(12);
        cmp("long_rise", rise, 2'b01);
        tick(19);
        cmp("long_early", long, 2'b00);
        tick(1);
        cmp("long_set", long, 2'b01);
        tick(8);
        in = 2'b00;
        tick(11);
        cmp("long_held", long, 2'b01);
        tick(1);
        cmp("long_fall", fall, 2'b01);
        cmp("long_clr", long, 2'b00);
        tick(4);

        // Reset mid-press
        in = 2'b11;
        tick(12);
        cmp("mid_rspress", rspress, 2'b11);
        cmp("mid_press", press, 2'b11);
        rst = 1'b0;
        tick(1);
        cmp("mid_rst_rspress", rspress, 2'b00);
        cmp("mid_rst_press", press, 2'b00);
        rst = 1'b1;
        in = 2'b01;
        tick(11);
        cmp("mid_edge11", rspress, 2'b00);
        tick(1);
        cmp("mid_rerise", rise, 2'b01);
        cmp("mid_press1", press, 2'b01);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
